// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: issues reads to a registered instruction memory and
// queues the returned bytes in a prefetch FIFO for decode.
// Optional perf counters are enabled with the macro IMEM_FETCH_PERF_CNT_EN.

module imem_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target
`ifdef IMEM_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_tag_q, inflight_tag_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [CNT_W:0]   occupancy;

  // A slot is reserved for every read in flight, so the FIFO can never overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    inflight_tag_d = inflight_tag_q;
    fetch_pc_d     = fetch_pc_q;

    not_empty = (count_q != '0);
    occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    issue     = reset && !branch_valid && (occupancy < DEPTH_OCC);
    pop       = not_empty && instr_ready;
    push      = inflight_q && !branch_valid;
    inflight_d = issue;

    if (branch_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = branch_target;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (issue) begin
        inflight_tag_d = fetch_pc_q;
        fetch_pc_d     = fetch_pc_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= RESET_ADDR;
      fetch_pc_q     <= RESET_ADDR;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      fetch_pc_q     <= fetch_pc_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= inflight_tag_q;
    end
  end

  assign mem_rd_en   = issue;
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = not_empty;
  assign instruction = not_empty ? data_mem[rd_ptr_q] : '0;
  assign pc_out      = not_empty ? pc_mem[rd_ptr_q] : RESET_ADDR;

  no_overfill: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count_q == DEPTH_CNT)));

`ifdef IMEM_FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (not_empty && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (branch_valid && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.

module tb_imem_fetch_unit;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instruction;
  logic [7:0] pc_out;
  logic       branch_valid;
  logic [7:0] branch_target;
`ifdef IMEM_FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  imem_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .pc_out(pc_out),
    .branch_valid(branch_valid),
    .branch_target(branch_target)
`ifdef IMEM_FETCH_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Instruction memory: byte at address a is a*17+1, registered read.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i * 17 + 1);
  always @(posedge clk) if (mem_rd_en === 1'b1) mem_rdata <= mem[mem_addr];

  // Reference model: queue of {pc, data} plus one outstanding read.
  typedef struct {
    logic [7:0] pc;
    logic [7:0] data;
  } entry_t;

  entry_t     mq[$];
  logic [7:0] m_pc = 8'h00;
  bit         m_inflight = 1'b0;
  logic [7:0] m_tag = 8'h00;
  bit         model_live = 1'b0;
  int         m_stall = 0;
  int         m_flush = 0;

  always @(posedge clk) begin
    bit iss;
    iss = (reset === 1'b1) && (branch_valid === 1'b0) && (mq.size() + int'(m_inflight) < DEPTH);
    if (reset === 1'b0) begin
      mq.delete();
      m_inflight = 1'b0;
      m_pc       = 8'h00;
      m_stall    = 0;
      m_flush    = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (mq.size() > 0 && !instr_ready && m_stall < 65535) m_stall++;
      if (branch_valid && m_flush < 65535) m_flush++;
      if (mq.size() > 0 && instr_ready) mq.delete(0);
      if (branch_valid) begin
        mq.delete();
        m_inflight = 1'b0;
        m_pc       = branch_target;
      end else begin
        if (m_inflight) mq.push_back('{pc: m_tag, data: mem[m_tag]});
        m_inflight = iss;
        if (iss) begin
          m_tag = m_pc;
          m_pc  = m_pc + 8'd1;
        end
      end
    end
  end

  // Per-cycle comparison and transfer log, sampled on the falling edge.
  logic [15:0] xfer_log[$];
  int          rd_count = 0;

  always @(negedge clk) begin
    if (model_live) begin
      bit exp_rd;
      exp_rd = (reset === 1'b1) && (branch_valid === 1'b0) && (mq.size() + int'(m_inflight) < DEPTH);
      check("mdl_rd_en", mem_rd_en, exp_rd);
      if (exp_rd) check("mdl_mem_addr", mem_addr, m_pc);
      check("mdl_instr_valid", instr_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("mdl_instruction", instruction, mq[0].data);
        check("mdl_pc_out", pc_out, mq[0].pc);
      end
`ifdef IMEM_FETCH_PERF_CNT_EN
      check("mdl_stall_cnt", stall_cnt, m_stall);
      check("mdl_flush_cnt", flush_cnt, m_flush);
`endif
      if (mem_rd_en === 1'b1) rd_count++;
      if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1)
        xfer_log.push_back({pc_out, instruction});
    end
  end

  function automatic logic [15:0] logat(input int idx);
    if (idx < xfer_log.size()) return xfer_log[idx];
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset        = 1'b0;
    branch_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int base;
    int rd_base;
    int rst_base;
    int n3;
    bit found;
    logic [15:0] e;

    reset         = 1'b0;
    instr_ready   = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instruction", instruction, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Basic fetch
    reset = 1'b1;
    #1;
    check("basic_first_rd_en", mem_rd_en, 1);
    check("basic_first_addr", mem_addr, 0);
    tick();
    check("basic_valid_edge1", instr_valid, 0);
    tick();
    check("basic_valid_edge2", instr_valid, 1);
    check("basic_instr0", {pc_out, instruction}, 16'h0001);
    tick();
    check("basic_instr1", {pc_out, instruction}, 16'h0112);
    tick();
    check("basic_instr2", {pc_out, instruction}, 16'h0223);

    // Backpressure
    instr_ready = 1'b0;
    restart();
    rd_base = rd_count;
    repeat (10) tick();
    check("bp_reads_issued", rd_count - rd_base, DEPTH);
    check("bp_rd_en_low", mem_rd_en, 0);
    check("bp_head_held", {instr_valid, pc_out, instruction}, 17'h0_0001 | 17'h1_0000);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("bp_stall_cnt", stall_cnt, 8);
`endif
    instr_ready = 1'b1;
    base = xfer_log.size();
    repeat (10) tick();
    check("bp_drain_count", xfer_log.size() - base, 10);
    for (int k = 0; k < 10; k++) begin
      e = logat(base + k);
      check("bp_drain_pc", e[15:8], k);
    end

    // Branch kills an in-flight read and the queued entries
    restart();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_rd_en && mem_addr == 8'h05) found = 1'b1;
      else tick();
    end
    check("br_reach_addr5", found, 1);
    tick();
    branch_valid  = 1'b1;
    branch_target = 8'h40;
    #1;
    check("br_no_issue", mem_rd_en, 0);
    tick();
    branch_valid = 1'b0;
    base = xfer_log.size();
    #1;
    check("br_target_issue", {mem_rd_en, mem_addr}, 9'h140);
    repeat (5) tick();
    check("br_first_after", logat(base), 16'h4041);
    check("br_second_after", logat(base + 1), 16'h4152);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("br_flush_cnt", flush_cnt, 1);
`endif

    // Branch and handshake in the same cycle
    restart();
    rst_base = xfer_log.size();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (instr_valid && pc_out == 8'h03) found = 1'b1;
    end
    check("same_reach_pc3", found, 1);
    base = xfer_log.size();
    branch_valid  = 1'b1;
    branch_target = 8'h10;
    tick();
    branch_valid = 1'b0;
    repeat (5) tick();
    e = logat(base);
    check("same_pc3_taken", e[15:8], 8'h03);
    e = logat(base + 1);
    check("same_next_target", e[15:8], 8'h10);
    n3 = 0;
    for (int i = rst_base; i < xfer_log.size(); i++) begin
      e = xfer_log[i];
      if (e[15:8] == 8'h03) n3++;
    end
    check("same_pc3_once", n3, 1);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("same_flush_cnt", flush_cnt, 1);
`endif

    // Wrap-around
    branch_valid  = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_valid = 1'b0;
    base = xfer_log.size();
    repeat (8) tick();
    check("wrap_fe", logat(base), 16'hFEDF);
    check("wrap_ff", logat(base + 1), 16'hFFF0);
    check("wrap_00", logat(base + 2), 16'h0001);
    e = logat(base + 3);
    check("wrap_01", e[15:8], 8'h01);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("wrap_flush_cnt", flush_cnt, 2);
`endif

    // Back-to-back branches: last target wins
    branch_valid  = 1'b1;
    branch_target = 8'h20;
    tick();
    branch_target = 8'h30;
    tick();
    branch_valid = 1'b0;
    base = xfer_log.size();
    repeat (6) tick();
    check("b2b_last_wins", logat(base), 16'h3031);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("b2b_flush_cnt", flush_cnt, 4);
`endif

    // Reset mid-operation with a full FIFO
    instr_ready = 1'b0;
    repeat (8) tick();
    check("midrst_full", instr_valid, 1);
    reset = 1'b0;
    tick();
    check("midrst_valid", instr_valid, 0);
    check("midrst_pc_out", pc_out, 0);
    check("midrst_instruction", instruction, 0);
`ifdef IMEM_FETCH_PERF_CNT_EN
    check("midrst_stall_cnt", stall_cnt, 0);
    check("midrst_flush_cnt", flush_cnt, 0);
`endif
    reset       = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("midrst_restart", {mem_rd_en, mem_addr}, 9'h100);
    base = xfer_log.size();
    repeat (6) tick();
    check("midrst_first", logat(base), 16'h0001);
    e = logat(base + 1);
    check("midrst_second", e[15:8], 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
